// File: rtl/regfile_multiport.sv
// Multiport register file: N_RD combinational read ports, ALU and load write ports,
// top address aliases pc_in, busy scoreboard for pending loads, post-reset clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle ld/wr data onto the read ports.

module regfile_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              run,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] PC_ADDR = {ADDR_W{1'b1}};

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{ld_en, ld_addr, ld_data, wr_en, wr_addr, wr_data};
`endif

    always_comb begin
        data = '0;
        busy = 1'b0;
        if (run) begin
            if (addr == PC_ADDR) begin
                data = pc_in;
            end else begin
                data = mem_data;
                busy = mem_busy;
`ifdef REGFILE_BYPASS_EN
                // A returning load satisfies the reservation, so it also hides busy.
                if (ld_en && ld_addr == addr) begin
                    data = ld_data;
                    busy = 1'b0;
                end else if (wr_en && wr_addr == addr) begin
                    data = wr_data;
                end
`endif
            end
        end
    end
endmodule

module regfile_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int N_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_busy,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     ld_en,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     ready
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ADDR  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] LAST_IDX = PC_ADDR - 1'b1;

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0]            state;
    logic [ADDR_W-1:0]     idx;
    logic [DATA_W-1:0]     mem [0:NUM_REGS-2];
    logic [NUM_REGS-2:0]   busy;

    logic run;
    assign run   = (state == RUN);
    assign ready = run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
        end else if (state == CLEAR) begin
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) state <= RUN;
        end
    end

    // No reset on the array itself; the sweep zeroes it so it can map to distributed RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[idx] <= '0;
            end else begin
                if (wr_en && wr_addr != PC_ADDR) mem[wr_addr] <= wr_data;
                if (ld_en && ld_addr != PC_ADDR) mem[ld_addr] <= ld_data;
            end
        end
    end

    // Reservation is applied after the load clear so a same-cycle re-issue stays busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (state == RUN) begin
            if (ld_en && ld_addr != PC_ADDR)   busy[ld_addr]  <= 1'b0;
            if (rsv_en && rsv_addr != PC_ADDR) busy[rsv_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] raw_data;
        logic              raw_busy;

        assign a        = rd_addr[i*ADDR_W +: ADDR_W];
        assign raw_data = (a == PC_ADDR) ? '0 : mem[a];
        assign raw_busy = (a == PC_ADDR) ? 1'b0 : busy[a];

        regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port (
            .run      (run),
            .addr     (a),
            .mem_data (raw_data),
            .mem_busy (raw_busy),
            .pc_in    (pc_in),
            .ld_en    (ld_en),
            .ld_addr  (ld_addr),
            .ld_data  (ld_data),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .data     (rd_data[i*DATA_W +: DATA_W]),
            .busy     (rd_busy[i])
        );
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: directed scenarios plus random traffic against a reference model.
module tb_regfile_multiport;
    localparam int DW = 32, AW = 4, NR = 2, NREG = 16, PC = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic [DW-1:0]     pc_in;
    logic              wr_en, ld_en, rsv_en, ready;
    logic [AW-1:0]     wr_addr, ld_addr, rsv_addr;
    logic [DW-1:0]     wr_data, ld_data;

    regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .pc_in(pc_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .ready(ready)
    );

    int checks = 0, errors = 0;
    logic [DW-1:0] m_mem [NREG];
    bit            m_busy [NREG];
    int            m_left = NREG - 1;   // sweep edges still to go; 0 means running
    bit            armed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void exp_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output bit b);
        d = '0; b = 0;
        if (m_left == 0) begin
            if (a == PC) d = pc_in;
            else begin
                d = m_mem[a]; b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
                if (ld_en && ld_addr == a) begin d = ld_data; b = 0; end
                else if (wr_en && wr_addr == a) d = wr_data;
`endif
            end
        end
    endfunction

    task automatic check_all();
        logic [DW-1:0] d; bit b;
        chk("ready", ready, m_left == 0);
        for (int p = 0; p < NR; p++) begin
            exp_read(rd_addr[p*AW +: AW], d, b);
            chk($sformatf("rd_data%0d", p), rd_data[p*DW +: DW], d);
            chk($sformatf("rd_busy%0d", p), rd_busy[p], b);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_left = NREG - 1;
            for (int r = 0; r < NREG; r++) m_busy[r] = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) for (int r = 0; r < NREG; r++) m_mem[r] = '0;
        end else begin
            if (wr_en && wr_addr != PC) m_mem[wr_addr] = wr_data;
            if (ld_en && ld_addr != PC) begin m_mem[ld_addr] = ld_data; m_busy[ld_addr] = 0; end
            if (rsv_en && rsv_addr != PC) m_busy[rsv_addr] = 1;
        end
    endtask

    // Inputs are set at the falling edge; check, take the rising edge, update model.
    task automatic cyc();
        #1;
        if (armed) check_all();
        @(posedge clk);
        model_edge();
        armed = 1;
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; wr_en = 0; ld_en = 0; rsv_en = 0;
    endtask

    task automatic peek(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic b);
        rd_addr[0 +: AW] = a;
        #1;
        d = rd_data[0 +: DW];
        b = rd_busy[0];
    endtask

    task automatic sweep(input string tag);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ready) break;
            n++;
            cyc();
        end
        chk(tag, n, 15);
    endtask

    logic [DW-1:0] d;
    logic          b;

    initial begin
        idle(); rst = 1; rd_addr = '0; pc_in = 32'h100;
        wr_addr = 0; ld_addr = 0; rsv_addr = 0; wr_data = 0; ld_data = 0;
        @(negedge clk);
        cyc();
        chk("rst_ready", ready, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_busy", rd_busy, 0);
        idle();
        sweep("sweep_edges");
        for (int r = 0; r < PC; r++) begin
            peek(r[AW-1:0], d, b);
            chk($sformatf("clr_r%0d", r), {b, d}, 0);
        end

        // basic write/read, PC alias
        wr_en = 1; wr_addr = 3; wr_data = 32'hDEADBEEF; cyc(); idle();
        peek(3, d, b); chk("r3", d, 32'hDEADBEEF);
        peek(15, d, b); chk("pc_read", {b, d}, {1'b0, 32'h100});
        wr_en = 1; wr_addr = 15; wr_data = 32'h55; rsv_en = 1; rsv_addr = 15; cyc(); idle();
        peek(15, d, b); chk("pc_nowr", {b, d}, {1'b0, 32'h100});

        // write collision
        wr_en = 1; wr_addr = 5; wr_data = 32'h11; ld_en = 1; ld_addr = 5; ld_data = 32'h22;
        rd_addr[0 +: AW] = 5;
`ifdef REGFILE_BYPASS_EN
        #1 chk("coll_bypass", rd_data[0 +: DW], 32'h22);
`endif
        cyc(); idle();
        peek(5, d, b); chk("coll_r5", d, 32'h22);

        // scoreboard
        rsv_en = 1; rsv_addr = 7; cyc(); idle();
        peek(7, d, b); chk("rsv_busy", b, 1);
        wr_en = 1; wr_addr = 7; wr_data = 32'h5; cyc(); idle();
        peek(7, d, b); chk("wr_busy_kept", {b, d}, {1'b1, 32'h5});
        ld_en = 1; ld_addr = 7; ld_data = 32'h9; cyc(); idle();
        peek(7, d, b); chk("ld_clears", {b, d}, {1'b0, 32'h9});
        rsv_en = 1; rsv_addr = 7; ld_en = 1; ld_addr = 7; ld_data = 32'hA; cyc(); idle();
        peek(7, d, b); chk("rsv_ld_same", {b, d}, {1'b1, 32'hA});

        // no-bypass latency (bypass build expects the forwarded value)
        wr_en = 1; wr_addr = 4; wr_data = 32'h12; cyc(); idle();
        wr_en = 1; wr_addr = 4; wr_data = 32'h77; rd_addr[0 +: AW] = 4;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cyc_r4", rd_data[0 +: DW], 32'h77);
`else
        chk("same_cyc_r4", rd_data[0 +: DW], 32'h12);
`endif
        cyc(); idle();
        peek(4, d, b); chk("next_cyc_r4", d, 32'h77);

        // reset mid-run
        rsv_en = 1; rsv_addr = 2; wr_en = 1; wr_addr = 2; wr_data = 32'hAA; cyc(); idle();
        peek(2, d, b); chk("pre_rst_r2", {b, d}, {1'b1, 32'hAA});
        rst = 1; cyc(); idle();
        peek(2, d, b); chk("rst_busy_r2", b, 0);
        repeat (6) cyc();
        rst = 1; cyc(); idle();   // mid-sweep restart
        sweep("resweep_edges");
        peek(2, d, b); chk("post_rst_r2", {b, d}, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            wr_en    = $urandom_range(0, 1);
            ld_en    = $urandom_range(0, 1);
            rsv_en   = $urandom_range(0, 2) == 0;
            wr_addr  = $urandom_range(0, 15);
            ld_addr  = $urandom_range(0, 15);
            rsv_addr = $urandom_range(0, 15);
            wr_data  = $urandom;
            ld_data  = $urandom;
            pc_in    = $urandom;
            for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = $urandom_range(0, 15);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
